// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the RAM.
// The slave modport is the arbiter's view; the master modport is the
// surrounding core/RAM environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12
);
  // Instruction-fetch port
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ready;
  logic [31:0]       if_data;
  // Data port
  logic              d_req;
  logic              d_rw;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wmask;
  logic              d_ready;
  logic [31:0]       d_rdata;
  logic              d_err;
  // Single-port RAM side
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_addr, d_wdata, d_wmask, ram_rdata,
    output if_ready, if_data, d_ready, d_rdata, d_err,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_rw, d_addr, d_wdata, d_wmask, ram_rdata,
    input  if_ready, if_data, d_ready, d_rdata, d_err,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch port and the data port. Each access takes two cycles:
// the grant cycle drives the RAM, the following WAIT cycle pulses ready and
// captures the read data. Out-of-range addresses never reach the RAM and get
// a nop (fetch) or an error response (data).
module mem_arbiter #(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_reg;
  logic        last_reg;     // 0 = IF served last, 1 = D served last
  logic        granted_reg;  // requester owning the current WAIT cycle
  logic        read_reg;     // current access is a read (fetch or data read)
  logic        oor_reg;      // current access was out of range
  logic [31:0] if_data_reg;
  logic [31:0] d_rdata_reg;

  // Per-requester address decode, index 0 = IF, 1 = D
  logic [31:0]       req_addr  [2];
  logic [31:0]       offset    [2];
  logic              in_range  [2];
  logic [ADDR_W-1:0] word_addr [2];

  assign req_addr[0] = bus.if_addr;
  assign req_addr[1] = bus.d_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_decode
      // Subtracting BASE makes addresses below BASE wrap to huge offsets, so
      // a single upper-bits-zero test covers both ends of the window.
      assign offset[gi]    = req_addr[gi] - BASE;
      assign in_range[gi]  = (offset[gi] >> (ADDR_W + 2)) == 32'd0;
      assign word_addr[gi] = offset[gi][ADDR_W+1:2];
    end
  endgenerate

  logic              grant_valid;
  logic              grant_d;
  logic              ram_en_c;
  logic [3:0]        ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [31:0]       ram_wdata_c;

  // Combinational grant and RAM drive; everything is held at zero in reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_d     = 1'b0;
    ram_en_c    = 1'b0;
    ram_we_c    = 4'b0000;
    ram_addr_c  = '0;
    ram_wdata_c = 32'd0;
    if (!rst && state_reg == IDLE && (bus.if_req || bus.d_req)) begin
      grant_valid = 1'b1;
      // On conflict, serve whoever did not go last.
      grant_d     = bus.d_req && (!bus.if_req || !last_reg);
      ram_addr_c  = word_addr[grant_d];
      if (in_range[grant_d]) begin
        ram_en_c = 1'b1;
        if (grant_d && bus.d_rw) begin
          ram_we_c    = bus.d_wmask;
          ram_wdata_c = bus.d_wdata;
        end
      end
    end
  end

  assign bus.ram_en    = ram_en_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;

  // Ready is a pure decode of the WAIT state so a reset during WAIT
  // suppresses the pulse in that very cycle.
  assign bus.if_ready = (state_reg == WAIT) && !granted_reg && !rst;
  assign bus.d_ready  = (state_reg == WAIT) &&  granted_reg && !rst;
  assign bus.d_err    = bus.d_ready && oor_reg;
  assign bus.if_data  = if_data_reg;
  assign bus.d_rdata  = d_rdata_reg;

  // Arbitration FSM with per-port read data capture in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b0;
      granted_reg <= 1'b0;
      read_reg    <= 1'b0;
      oor_reg     <= 1'b0;
      if_data_reg <= 32'd0;
      d_rdata_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            last_reg    <= grant_d;
            granted_reg <= grant_d;
            read_reg    <= !(grant_d && bus.d_rw);
            oor_reg     <= !in_range[grant_d];
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          state_reg <= IDLE;
          if (read_reg) begin
            if (granted_reg) begin
              d_rdata_reg <= oor_reg ? 32'd0 : bus.ram_rdata;
            end else begin
              if_data_reg <= oor_reg ? NOP_INSN : bus.ram_rdata;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone fetch, byte write/read-back,
// contention ordering, out-of-range responses and reset during WAIT.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.ADDR_W(12)) bus ();

  mem_arbiter #(
    .ADDR_W(12),
    .BASE  (32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, byte-lane writes, known words loaded in reset.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (rst) begin
      mem[2] <= 32'hAABBCCDD;
      mem[5] <= 32'hDEADBEEF;
    end else if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_we[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed contention table: D(word 2), IF(word 5) alternating.
  logic        exp_en [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  logic [11:0] exp_ad [8] = '{12'd2, 12'd0, 12'd5, 12'd0, 12'd2, 12'd0, 12'd5, 12'd0};
  logic        exp_dr [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
  logic        exp_ir [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h14;
    bus.d_req   = 1'b1;
    bus.d_rw    = 1'b0;
    bus.d_addr  = 32'h8;
    bus.d_wdata = 32'd0;
    bus.d_wmask = 4'd0;

    // Reset held two cycles with both requests high
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_ram_en", bus.ram_en, 0);
      check("rst_if_ready", bus.if_ready, 0);
      check("rst_d_ready", bus.d_ready, 0);
      check("rst_if_data", bus.if_data, 0);
      check("rst_d_rdata", bus.d_rdata, 0);
    end

    // First grant after reset goes to D (word 2)
    cyc(); rst = 1'b0; #1;
    check("first_en", bus.ram_en, 1);
    check("first_addr_d", bus.ram_addr, 2);
    check("first_we", bus.ram_we, 0);
    cyc();
    check("first_d_ready", bus.d_ready, 1);
    check("first_if_ready", bus.if_ready, 0);
    check("first_d_err", bus.d_err, 0);

    // Lone fetch of 0x14 -> word 5
    cyc(); bus.d_req = 1'b0; #1;
    check("first_d_rdata", bus.d_rdata, 32'hAABBCCDD);
    check("fetch_en", bus.ram_en, 1);
    check("fetch_addr", bus.ram_addr, 5);
    cyc();
    check("fetch_if_ready", bus.if_ready, 1);
    check("fetch_d_ready", bus.d_ready, 0);
    check("fetch_data_not_yet", bus.if_data, 0);
    cyc(); bus.if_req = 1'b0; #1;
    check("fetch_data", bus.if_data, 32'hDEADBEEF);
    check("idle_en", bus.ram_en, 0);

    // Byte write to 0x8, lane 1 only
    cyc();
    bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_addr = 32'h8;
    bus.d_wdata = 32'h11223344; bus.d_wmask = 4'b0010; #1;
    check("wr_en", bus.ram_en, 1);
    check("wr_we", bus.ram_we, 4'b0010);
    check("wr_wdata", bus.ram_wdata, 32'h11223344);
    cyc(); bus.d_wdata = 32'hFFFFFFFF; #1;
    check("wr_d_ready", bus.d_ready, 1);
    check("wr_d_err", bus.d_err, 0);
    cyc(); bus.d_rw = 1'b0; #1;
    check("rd_we", bus.ram_we, 0);
    check("rd_en", bus.ram_en, 1);
    check("wr_keeps_rdata", bus.d_rdata, 32'hAABBCCDD);
    cyc();
    check("rd_d_ready", bus.d_ready, 1);
    cyc(); bus.d_req = 1'b0; #1;
    check("rd_data_byte1", bus.d_rdata, 32'hAABB33DD);

    // Contention from reset: D, IF, D, IF
    cyc();
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h14;
    bus.d_req  = 1'b1; bus.d_addr  = 32'h8; bus.d_rw = 1'b0;
    cyc(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("cont%0d_en", k), bus.ram_en, exp_en[k]);
      if (exp_en[k]) check($sformatf("cont%0d_addr", k), bus.ram_addr, exp_ad[k]);
      check($sformatf("cont%0d_d_ready", k), bus.d_ready, exp_dr[k]);
      check($sformatf("cont%0d_if_ready", k), bus.if_ready, exp_ir[k]);
      cyc();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;

    // Out-of-range data read and fetch at 0x4000
    cyc(); bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h4000; #1;
    check("oor_d_en", bus.ram_en, 0);
    check("oor_d_we", bus.ram_we, 0);
    cyc();
    check("oor_d_ready", bus.d_ready, 1);
    check("oor_d_err", bus.d_err, 1);
    cyc(); bus.d_req = 1'b0; #1;
    check("oor_d_rdata", bus.d_rdata, 0);
    check("oor_d_err_low", bus.d_err, 0);
    bus.if_req = 1'b1; bus.if_addr = 32'h4000; #1;
    check("oor_if_en", bus.ram_en, 0);
    cyc();
    check("oor_if_ready", bus.if_ready, 1);
    cyc(); bus.if_req = 1'b0; #1;
    check("oor_if_nop", bus.if_data, 32'h00000013);

    // Reset during the WAIT cycle of a fetch
    cyc(); bus.if_req = 1'b1; bus.if_addr = 32'h14; #1;
    check("midrst_grant_en", bus.ram_en, 1);
    cyc(); rst = 1'b1; #1;
    check("midrst_no_ready", bus.if_ready, 0);
    check("midrst_en", bus.ram_en, 0);
    cyc(); rst = 1'b0; #1;
    check("midrst_regrant_en", bus.ram_en, 1);
    check("midrst_regrant_addr", bus.ram_addr, 5);
    cyc();
    check("midrst_if_ready", bus.if_ready, 1);
    cyc(); bus.if_req = 1'b0; #1;
    check("midrst_if_data", bus.if_data, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter between `riscv_core` and a single-port synchronous RAM. It lets the instruction-fetch port and the data port share one RAM with round-robin arbitration and a request/ready handshake. Out-of-range accesses get a defined error response instead of touching the RAM. It sits between the core's `if_*` / `mem_*` buses and the unified program/data RAM inside `perip`.

## Interface
Parameters:
- `ADDR_W`, 12: RAM word-address width (RAM holds 2^ADDR_W 32-bit words).
- `BASE`, 32'h0000_0000: byte address of RAM word 0; must be aligned to 4·2^ADDR_W.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_ready`.
- `if_addr`  in  32  fetch byte address.
- `if_ready`  out  1  one-cycle pulse: fetch done, `if_data` valid.
- `if_data`  out  32  registered fetch data; holds until the next `if_ready`.
- `d_req`  in  1  data request; held high until `d_ready`.
- `d_rw`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  write data.
- `d_wmask`  in  4  byte-lane write enables.
- `d_ready`  out  1  one-cycle pulse: data access done.
- `d_rdata`  out  32  registered read data; holds until the next read `d_ready`.
- `d_err`  out  1  valid with `d_ready`: address was out of range.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  4  RAM byte write enables.
- `ram_addr`  out  ADDR_W  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, valid the cycle after `ram_en`.

## Operation
- The FSM has two states, IDLE and WAIT. It also keeps a `last` register (0 = IF, 1 = D) and a `granted` register.
- **Arbitration in IDLE** (combinational grant):
  - Only one requester: that one is granted.
  - Both requesters: the one not equal to `last` is granted.
  - On a grant: `last` ← grantee, `granted` ← grantee, state → WAIT.
- **RAM drive in the grant cycle:**
  - `ram_addr` = (addr − BASE)[ADDR_W+1:2]; byte-offset bits [1:0] are ignored.
  - In-range access: `ram_en`=1.
  - Data write: `ram_we` = `d_wmask`, `ram_wdata` = `d_wdata`.
  - Read: `ram_we`=0.
- **Range check:** in range when BASE ≤ addr < BASE + 4·2^ADDR_W.
  - Out-of-range access: `ram_en`=0, `ram_we`=0.
  - Out-of-range fetch: `if_data` ← 32'h0000_0013 (nop); `if_ready` pulses.
  - Out-of-range data access: `d_rdata` ← 0, `d_err`=1 with `d_ready`.
- **WAIT state** (always one cycle, then → IDLE):
  - Pulse `ready` of the `granted` requester.
  - Read: capture `ram_rdata` into that requester's data register.
  - No new grant is issued in WAIT.
  - `ram_en` and `ram_we` are 0.
- A write leaves `d_rdata` unchanged.
- `ram_en` and `ram_we` are forced to 0 while `rst` is high.
- Address and data inputs are sampled only in the grant cycle. Changes while in WAIT are ignored.

## Timing
- Reset values:
  - state=IDLE, `last`=IF (so the first conflict goes to D).
  - `if_ready`=0, `d_ready`=0, `d_err`=0, `if_data`=0, `d_rdata`=0.
  - `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
- Latency: request seen high in cycle N (IDLE) → `ram_en` in N → `ready` pulse in N+1 → data readable from N+2 onward (registered).
- Throughput: one access per 2 cycles.
  - A lone requester holding `req` high gets back-to-back accesses at N, N+2, N+4, …
  - Under continuous contention, accesses alternate D, IF, D, IF, … (starting from reset).
- Handshake:
  - `req` must stay high through the `ready` cycle.
  - Deasserting `req` in the grant cycle is illegal.
  - `req` may be deasserted or held for a new access in the cycle after `ready`.
- `rst` asserted in WAIT:
  - No `ready` pulse; state → IDLE next cycle.
  - The access is lost (a write already issued stays written).
- `ready` pulses never coincide on IF and D.
- `d_err` is 0 whenever `d_ready` is 0.

## Test plan
- **Reset:** hold `rst` 2 cycles with `if_req`=`d_req`=1 → `ram_en`=0, both ready=0, `if_data`=`d_rdata`=0. Release → first grant is D.
- **Lone fetch:** RAM[5]=32'hDEADBEEF, `if_addr`=32'h14 held → `ram_en` with `ram_addr`=5 in cycle N, `if_ready` in N+1, `if_data`=32'hDEADBEEF from N+2.
- **Byte write then read:** D write to 32'h8 with `d_wdata`=32'h11223344, `d_wmask`=4'b0010 → `ram_we`=4'b0010. A following read of 32'h8 returns only byte1=8'h33 changed; `d_err`=0.
- **Contention:** `if_req`=`d_req`=1 held for 8 cycles → grants D, IF, D, IF. Ready pulses in cycles 1, 3, 5, 7, never both at once.
- **Out of range** (ADDR_W=12): D read of 32'h4000 → `ram_en`=0; `d_ready`=1 and `d_err`=1 next cycle; `d_rdata`=0. IF fetch of 32'h4000 → `if_data`=32'h00000013.
- **Reset mid-op:** assert `rst` in the WAIT cycle of a fetch → no `if_ready` pulse; after release the fetch is regranted and completes normally.
